// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the configurable UART.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  localparam logic [15:0] MIN_DIVISOR = 16'd4;

  // True when the mode carries a parity bit (reserved code 3 behaves as none).
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Parity bit that makes the frame even/odd over data plus parity.
  function automatic logic parity_of(input logic [7:0] data, input logic [1:0] mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  // A pop frees the slot a simultaneous push needs, so a full FIFO accepts both.
  always_comb begin
    do_rd   = rd_en && (count != '0);
    do_wr   = wr_en && ((count != FULL_COUNT) || do_rd);
    empty   = (count == '0);
    level   = count;
    rd_data = mem[rd_ptr];
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_configurable.sv
// Configurable UART: runtime divisor/parity/stop bits, FIFOs, flow control, error flags.
module uart_configurable
  import uart_pkg::*;
#(
  parameter int unsigned DEFAULT_DIVISOR = 2083,
  parameter int unsigned FIFO_AW         = 4,
  parameter int unsigned RTS_MARGIN      = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rxd,
  output logic               txd,
  input  logic               cts,
  output logic               rts,
  input  logic [7:0]         tx_data,
  input  logic               write_enable,
  output logic               tx_fifo_full,
  output logic               tx_busy,
  output logic [7:0]         rx_data,
  input  logic               read_enable,
  output logic               rx_data_ready,
  output logic [FIFO_AW:0]   rx_fifo_level,
  input  logic               divisor_wr,
  input  logic [15:0]        divisor_in,
  input  logic [1:0]         parity_mode,
  input  logic               two_stop_bits,
  output logic               parity_error,
  output logic               framing_error,
  output logic               overrun_error,
  input  logic               clear_errors
);

  localparam logic [FIFO_AW:0] FIFO_FULL = {1'b1, {FIFO_AW{1'b0}}};

  logic [15:0] divisor;

  // TX path state
  tx_state_t        tx_state;
  logic [15:0]      tx_cnt, tx_div;
  logic [3:0]       tx_bit;
  logic [7:0]       tx_shift, tx_head;
  logic             tx_par_en, tx_par_bit, tx_stop2;
  logic             tx_empty, tx_pop;
  logic [FIFO_AW:0] tx_level;

  // RX path state
  rx_state_t        rx_state;
  logic             rx_s1, rx_s2, rx_prev;
  logic [15:0]      rx_cnt, rx_div;
  logic [3:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic [1:0]       rx_mode;
  logic             rx_par;
  logic             rx_sample, rx_push, rx_wr, rx_rd, rx_empty, rx_full;
  logic [FIFO_AW:0] rx_level, rx_level_next, rx_free;

  // Divisor register, clamped to the minimum usable bit period.
  always_ff @(posedge clock) begin
    if (reset)           divisor <= 16'(DEFAULT_DIVISOR);
    else if (divisor_wr) divisor <= (divisor_in < MIN_DIVISOR) ? MIN_DIVISOR : divisor_in;
  end

  uart_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
    .clock(clock), .reset(reset), .clear(1'b0),
    .wr_en(write_enable), .wr_data(tx_data),
    .rd_en(tx_pop), .rd_data(tx_head),
    .empty(tx_empty), .level(tx_level)
  );

  uart_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
    .clock(clock), .reset(reset), .clear(1'b0),
    .wr_en(rx_wr), .wr_data(rx_shift),
    .rd_en(read_enable), .rd_data(rx_data),
    .empty(rx_empty), .level(rx_level)
  );

  // Status decode, FIFO handshakes and the RX sample strobe.
  always_comb begin
    tx_pop        = (tx_state == TX_IDLE) && !tx_empty && !cts;
    tx_busy       = (tx_state != TX_IDLE) || !tx_empty;
    tx_fifo_full  = (tx_level == FIFO_FULL);
    rx_full       = (rx_level == FIFO_FULL);
    rx_data_ready = !rx_empty;
    rx_fifo_level = rx_level;
    rx_sample     = (rx_state == RX_START) ? (rx_cnt == (rx_div >> 1)) : (rx_cnt == rx_div - 16'd1);
    rx_push       = (rx_state == RX_STOP) && rx_sample;
    rx_wr         = rx_push && !rx_full;
    rx_rd         = read_enable && !rx_empty;
    rx_level_next = rx_level + {{FIFO_AW{1'b0}}, rx_wr} - {{FIFO_AW{1'b0}}, rx_rd};
    rx_free       = FIFO_FULL - rx_level_next;
  end

  // TX frame sequencer; txd is registered and driven on each bit boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      txd        <= 1'b1;
      tx_cnt     <= '0;
      tx_div     <= MIN_DIVISOR;
      tx_bit     <= '0;
      tx_shift   <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_stop2   <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      txd <= 1'b1;
      if (tx_pop) begin
        tx_state   <= TX_START;
        txd        <= 1'b0;
        tx_cnt     <= '0;
        tx_div     <= divisor;
        tx_shift   <= tx_head;
        tx_par_en  <= parity_on(parity_mode);
        tx_par_bit <= parity_of(tx_head, parity_mode);
        tx_stop2   <= two_stop_bits;
      end
    end else if (tx_cnt == tx_div - 16'd1) begin
      tx_cnt <= '0;
      case (tx_state)
        TX_START: begin
          tx_state <= TX_DATA;
          tx_bit   <= '0;
          txd      <= tx_shift[0];
        end
        TX_DATA: begin
          if (tx_bit == 4'd7) begin
            tx_bit   <= '0;
            tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
            txd      <= tx_par_en ? tx_par_bit : 1'b1;
          end else begin
            tx_bit   <= tx_bit + 4'd1;
            tx_shift <= tx_shift >> 1;
            txd      <= tx_shift[1];
          end
        end
        TX_PARITY: begin
          tx_state <= TX_STOP;
          txd      <= 1'b1;
        end
        TX_STOP: begin
          txd <= 1'b1;
          if (tx_stop2 && tx_bit == 4'd0) tx_bit   <= 4'd1;
          else                            tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX frame sequencer and sticky error flags; a same-cycle event overrides clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_div        <= MIN_DIVISOR;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_mode       <= PAR_NONE;
      rx_par        <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (clear_errors) begin
        parity_error  <= 1'b0;
        framing_error <= 1'b0;
        overrun_error <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
            rx_div   <= divisor;
            rx_mode  <= parity_mode;
          end
        end
        RX_WAIT: begin
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: begin
          if (rx_sample) begin
            rx_cnt <= '0;
            case (rx_state)
              RX_START: begin
                rx_bit   <= '0;
                rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
              end
              RX_DATA: begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                if (rx_bit == 4'd7) rx_state <= parity_on(rx_mode) ? RX_PARITY : RX_STOP;
                else                rx_bit   <= rx_bit + 4'd1;
              end
              RX_PARITY: begin
                rx_par   <= rx_s2;
                rx_state <= RX_STOP;
              end
              RX_STOP: begin
                if (!rx_s2) framing_error <= 1'b1;
                if (parity_on(rx_mode) && (parity_of(rx_shift, rx_mode) != rx_par)) parity_error <= 1'b1;
                if (rx_full) overrun_error <= 1'b1;
                rx_state <= rx_s2 ? RX_IDLE : RX_WAIT;
              end
              default: rx_state <= RX_IDLE;
            endcase
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Flow control follows the occupancy the RX FIFO will have after this edge.
  always_ff @(posedge clock) begin
    if (reset) rts <= 1'b0;
    else       rts <= (32'(rx_free) <= RTS_MARGIN);
  end

endmodule
